// File: rtl/ecall_service_unit.sv
// Sequential ecall service controller: stalls the pipeline while it services
// PRINT_INT (display latch), READ_INT (debounced switch read) and EXIT (halt).
module ecall_service_unit #(
    parameter int          DATA_W          = 32,
    parameter int          SW_W            = 16,
    parameter int          DEBOUNCE_CYCLES = 200000,
    parameter int          HOLD_CYCLES     = 4,
    parameter logic [11:0] EOP_PRINT_INT   = 12'd1,
    parameter logic [11:0] EOP_READ_INT    = 12'd5,
    parameter logic [11:0] EOP_EXIT        = 12'd10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ecall_valid,
    input  logic [11:0]       ecall_code,
    input  logic [DATA_W-1:0] a0_in,
    input  logic              confirm_btn,
    input  logic [SW_W-1:0]   switch_in,
    output logic              stall,
    output logic              rd_we,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              eRead,
    output logic              eWrite,
    output logic [11:0]       EcallOp,
    output logic              halted
);

    localparam int DCW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [DCW-1:0] DB_MAX    = DCW'(DEBOUNCE_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRINT,
        S_WAIT_IN,
        S_WRBACK,
        S_DONE,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;

    logic              sync1_q, sync2_q;
    logic [DCW-1:0]    db_cnt_q, db_cnt_d;
    logic              db_level_q, db_level_d;
    logic              confirm_pulse;
    logic              recognised;

    // sync1 != sync2 means sync2 changes at this edge, so the stability count restarts with it
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (sync1_q != sync2_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + DCW'(1);
        end
        if (db_cnt_q == DB_MAX) begin
            db_level_d = sync2_q;
        end
    end

    assign confirm_pulse = (db_cnt_q == DB_MAX) && sync2_q && !db_level_q;

    assign recognised = (ecall_code == EOP_PRINT_INT) ||
                        (ecall_code == EOP_READ_INT)  ||
                        (ecall_code == EOP_EXIT);

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rd_data_d    = rd_data_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        stall        = 1'b0;
        rd_we        = 1'b0;
        eRead        = 1'b0;
        eWrite       = 1'b0;
        EcallOp      = 12'd0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ecall_valid && recognised) begin
                    stall = 1'b1;
                    if (ecall_code == EOP_PRINT_INT) begin
                        disp_data_d  = a0_in;
                        disp_valid_d = 1'b1;
                        hold_cnt_d   = '0;
                        state_d      = S_PRINT;
                    end else if (ecall_code == EOP_READ_INT) begin
                        state_d = S_WAIT_IN;
                    end else begin
                        state_d = S_HALT;
                    end
                end
            end
            S_PRINT: begin
                stall      = 1'b1;
                eWrite     = 1'b1;
                EcallOp    = EOP_PRINT_INT;
                // The acceptance cycle counts as the first stalled cycle
                hold_cnt_d = hold_cnt_q + HCW'(1);
                if (hold_cnt_d >= HOLD_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_IN: begin
                stall   = 1'b1;
                eRead   = 1'b1;
                EcallOp = EOP_READ_INT;
                if (confirm_pulse) begin
                    rd_data_d = DATA_W'($signed(switch_in));
                    state_d   = S_WRBACK;
                end
            end
            S_WRBACK: begin
                stall   = 1'b1;
                eRead   = 1'b1;
                EcallOp = EOP_READ_INT;
                rd_we   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_HALT: begin
                stall   = 1'b1;
                halted  = 1'b1;
                EcallOp = EOP_EXIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            rd_data_q    <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            db_level_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_data_q    <= rd_data_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            sync1_q      <= confirm_btn;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            db_level_q   <= db_level_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ecall_service_unit.sv
// Directed bench for ecall_service_unit with DEBOUNCE_CYCLES=8, HOLD_CYCLES=4.
module tb_ecall_service_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall_valid;
    logic [11:0] ecall_code;
    logic [31:0] a0_in;
    logic        confirm_btn;
    logic [15:0] switch_in;
    logic        stall;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        eRead;
    logic        eWrite;
    logic [11:0] EcallOp;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    ecall_service_unit #(
        .DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
        .a0_in(a0_in), .confirm_btn(confirm_btn), .switch_in(switch_in),
        .stall(stall), .rd_we(rd_we), .rd_data(rd_data), .disp_data(disp_data),
        .disp_valid(disp_valid), .eRead(eRead), .eWrite(eWrite), .EcallOp(EcallOp),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic s, input logic we, input logic er,
                            input logic ew, input logic [11:0] op, input logic h);
        check({tag, ".stall"},   {31'd0, stall},  {31'd0, s});
        check({tag, ".rd_we"},   {31'd0, rd_we},  {31'd0, we});
        check({tag, ".eRead"},   {31'd0, eRead},  {31'd0, er});
        check({tag, ".eWrite"},  {31'd0, eWrite}, {31'd0, ew});
        check({tag, ".EcallOp"}, {20'd0, EcallOp}, {20'd0, op});
        check({tag, ".halted"},  {31'd0, halted}, {31'd0, h});
    endtask

    task automatic chk_disp(input string tag, input logic [31:0] d, input logic v);
        check({tag, ".disp_data"},  disp_data, d);
        check({tag, ".disp_valid"}, {31'd0, disp_valid}, {31'd0, v});
    endtask

    initial begin
        rst_n       = 1'b0;
        ecall_valid = 1'b0;
        ecall_code  = 12'd0;
        a0_in       = 32'd0;
        confirm_btn = 1'b0;
        switch_in   = 16'd0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk_ctrl("reset", 0, 0, 0, 0, 12'd0, 0);
        chk_disp("reset", 32'd0, 0);
        check("reset.rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PRINT_INT: four stalled cycles, then DONE with stall low
        @(negedge clk);
        ecall_valid = 1'b1; ecall_code = 12'd1; a0_in = 32'hFFFF_FFF6;
        #1;
        chk_ctrl("print_accept", 1, 0, 0, 0, 12'd0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            chk_ctrl("print_hold", 1, 0, 0, 1, 12'd1, 0);
            chk_disp("print_hold", 32'hFFFF_FFF6, 1);
        end
        @(negedge clk); #1;
        chk_ctrl("print_done", 0, 0, 0, 0, 12'd0, 0);
        @(negedge clk);
        ecall_valid = 1'b0;
        #1;
        chk_ctrl("print_idle", 0, 0, 0, 0, 12'd0, 0);
        chk_disp("print_idle", 32'hFFFF_FFF6, 1);

        // unrecognised code acts as a NOP
        @(negedge clk);
        ecall_valid = 1'b1; ecall_code = 12'd7; a0_in = 32'h0000_1234;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk_ctrl("nop", 0, 0, 0, 0, 12'd0, 0);
            chk_disp("nop", 32'hFFFF_FFF6, 1);
        end
        @(negedge clk);
        ecall_valid = 1'b0;

        // press in IDLE is discarded; holding it must not repeat the pulse later
        confirm_btn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            chk_ctrl("btn_idle", 0, 0, 0, 0, 12'd0, 0);
        end
        @(negedge clk);
        ecall_valid = 1'b1; ecall_code = 12'd5; switch_in = 16'h8001;
        #1;
        chk_ctrl("read_accept", 1, 0, 0, 0, 12'd0, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            chk_ctrl("read_held", 1, 0, 1, 0, 12'd5, 0);
        end
        @(negedge clk);
        confirm_btn = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            chk_ctrl("read_release", 1, 0, 1, 0, 12'd5, 0);
        end

        // bounce: toggle every 3 cycles for 30 cycles, then hold high
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                if (j == 0) confirm_btn = (i % 2 == 0);
                #1;
                chk_ctrl("bounce", 1, 0, 1, 0, 12'd5, 0);
            end
        end
        @(negedge clk);
        confirm_btn = 1'b1;
        #1;
        chk_ctrl("bounce_last", 1, 0, 1, 0, 12'd5, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            chk_ctrl("debounce_wait", 1, 0, 1, 0, 12'd5, 0);
        end
        @(negedge clk); #1;
        chk_ctrl("read_wrback", 1, 1, 1, 0, 12'd5, 0);
        check("read_wrback.rd_data", rd_data, 32'hFFFF_8001);
        @(negedge clk); #1;
        chk_ctrl("read_done", 0, 0, 0, 0, 12'd0, 0);
        chk_disp("read_done", 32'hFFFF_FFF6, 1);
        @(negedge clk);
        ecall_valid = 1'b0;
        #1;
        chk_ctrl("read_idle", 0, 0, 0, 0, 12'd0, 0);

        // asynchronous reset while waiting for input
        @(negedge clk);
        confirm_btn = 1'b0;
        ecall_valid = 1'b1; ecall_code = 12'd5; switch_in = 16'h1234;
        #1;
        chk_ctrl("rst_read_accept", 1, 0, 0, 0, 12'd0, 0);
        @(negedge clk); #1;
        chk_ctrl("rst_read_wait", 1, 0, 1, 0, 12'd5, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ecall_valid = 1'b0;
        #1;
        chk_ctrl("rst_async", 0, 0, 0, 0, 12'd0, 0);
        chk_disp("rst_async", 32'd0, 0);
        check("rst_async.rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fresh READ_INT after reset completes cleanly
        @(negedge clk);
        ecall_valid = 1'b1; ecall_code = 12'd5;
        #1;
        chk_ctrl("read2_accept", 1, 0, 0, 0, 12'd0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk_ctrl("read2_wait", 1, 0, 1, 0, 12'd5, 0);
        end
        @(negedge clk);
        confirm_btn = 1'b1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            chk_ctrl("read2_debounce", 1, 0, 1, 0, 12'd5, 0);
        end
        @(negedge clk); #1;
        chk_ctrl("read2_wrback", 1, 1, 1, 0, 12'd5, 0);
        check("read2_wrback.rd_data", rd_data, 32'h0000_1234);
        @(negedge clk); #1;
        chk_ctrl("read2_done", 0, 0, 0, 0, 12'd0, 0);
        @(negedge clk);
        ecall_valid = 1'b0;
        confirm_btn = 1'b0;

        // EXIT halts permanently; later ecalls and presses are ignored
        @(negedge clk);
        ecall_valid = 1'b1; ecall_code = 12'd10;
        #1;
        chk_ctrl("exit_accept", 1, 0, 0, 0, 12'd0, 0);
        @(negedge clk);
        ecall_code = 12'd1; a0_in = 32'h0000_5555;
        #1;
        chk_ctrl("halt", 1, 0, 0, 0, 12'd10, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3)  confirm_btn = 1'b1;
            if (k == 10) ecall_code  = 12'd5;
            #1;
            chk_ctrl("halt_hold", 1, 0, 0, 0, 12'd10, 1);
            chk_disp("halt_hold", 32'd0, 0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        ecall_valid = 1'b0;
        #1;
        chk_ctrl("halt_reset", 0, 0, 0, 0, 12'd0, 0);
        chk_disp("halt_reset", 32'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
